// File: rtl/score_engine_pkg.sv
// Shared definitions for the wand-duel scoring engine: power-up codes,
// converter state encoding and the display-limit helper.
package score_pkg;

  localparam logic [1:0] PU_X1     = 2'b00;
  localparam logic [1:0] PU_X2     = 2'b01;
  localparam logic [1:0] PU_X4     = 2'b10;
  localparam logic [1:0] PU_SNITCH = 2'b11;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_LOAD  = 2'd1,
    CV_SHIFT = 2'd2,
    CV_DONE  = 2'd3
  } cv_state_e;

  // Largest value representable in the given number of decimal digits.
  function automatic int max_score(input int digits);
    int m;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction

endpackage

// File: rtl/score_engine_if.sv
// Player-facing bus of score_engine: game control and hit inputs in,
// binary scores, BCD bank and leader status out.
interface score_engine_if #(
    parameter int NUM_PLAYERS = 4,
    parameter int SCORE_W     = 14,
    parameter int DIGITS      = 4
);
    logic                              game_active;
    logic                              clear;
    logic [NUM_PLAYERS-1:0]            hit;
    logic [2*NUM_PLAYERS-1:0]          powerup;
    logic [SCORE_W*NUM_PLAYERS-1:0]    score;
    logic [4*DIGITS*NUM_PLAYERS-1:0]   bcd_digits;
    logic                              bcd_valid;
    logic [2:0]                        bcd_player;
    logic [2:0]                        leader;
    logic                              leader_tie;

    modport master (
        output game_active, clear, hit, powerup,
        input  score, bcd_digits, bcd_valid, bcd_player, leader, leader_tie
    );

    modport slave (
        input  game_active, clear, hit, powerup,
        output score, bcd_digits, bcd_valid, bcd_player, leader, leader_tie
    );
endinterface

// File: rtl/score_engine_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter.
// IDLE -> LOAD -> SHIFT (SCORE_W cycles) -> DONE; done is high for the DONE cycle.
module bcd_converter
    import score_pkg::*;
#(
    parameter int SCORE_W = 14,
    parameter int DIGITS  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    din,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + SCORE_W;
    localparam int CW = $clog2(SCORE_W + 1);

    cv_state_e         state;
    logic [SW-1:0]     sh;
    logic [SW-1:0]     sh_adj;
    logic [CW-1:0]     cnt;

    // Add-3 correction on every BCD nibble before each shift.
    always_comb begin
        sh_adj = sh;
        for (int d = 0; d < DIGITS; d++) begin
            if (sh[SCORE_W + 4*d +: 4] >= 4'd5)
                sh_adj[SCORE_W + 4*d +: 4] = sh[SCORE_W + 4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CV_IDLE;
            sh    <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            case (state)
                CV_IDLE: begin
                    done <= 1'b0;
                    if (start) state <= CV_LOAD;
                end
                CV_LOAD: begin
                    sh    <= {{BW{1'b0}}, din};
                    cnt   <= '0;
                    state <= CV_SHIFT;
                end
                CV_SHIFT: begin
                    sh  <= {sh_adj[SW-2:0], 1'b0};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(SCORE_W - 1)) begin
                        state <= CV_DONE;
                        done  <= 1'b1;
                    end
                end
                CV_DONE: begin
                    done  <= 1'b0;
                    state <= CV_IDLE;
                end
                default: state <= CV_IDLE;
            endcase
        end
    end

    assign bcd = sh[SW-1 -: BW];

endmodule

// File: rtl/score_engine.sv
// N-player scoring core: edge-detected hits, power-up increments, saturation,
// round-robin BCD bank refresh. Leader logic built only with SCORE_ENGINE_LEADER_EN.
module score_engine
    import score_pkg::*;
#(
    parameter int NUM_PLAYERS  = 4,
    parameter int SCORE_W      = 14,
    parameter int DIGITS       = 4,
    parameter int BASE_POINTS  = 10,
    parameter int SNITCH_BONUS = 150
) (
    input  logic           clock,
    input  logic           reset,
    score_engine_if.slave  bus
);
    localparam int               MAX_SCORE = max_score(DIGITS);
    localparam logic [SCORE_W:0] MAX_S     = (SCORE_W+1)'(MAX_SCORE);
    localparam logic [SCORE_W:0] INC_X1    = (SCORE_W+1)'(BASE_POINTS);
    localparam logic [SCORE_W:0] INC_X2    = (SCORE_W+1)'(BASE_POINTS * 2);
    localparam logic [SCORE_W:0] INC_X4    = (SCORE_W+1)'(BASE_POINTS * 4);
    localparam logic [SCORE_W:0] INC_SN    = (SCORE_W+1)'(SNITCH_BONUS);

    logic [NUM_PLAYERS-1:0][SCORE_W-1:0]  acc;
    logic [NUM_PLAYERS-1:0][4*DIGITS-1:0] bank;
    logic [NUM_PLAYERS-1:0]               hit_prev;
    logic [NUM_PLAYERS-1:0]               rise;
    logic [2:0]                           ptr;
    logic [SCORE_W-1:0]                   cv_din;
    logic [4*DIGITS-1:0]                  cv_bcd;
    logic                                 cv_done;
    logic                                 bcd_valid_q;
    logic [2:0]                           bcd_player_q;

    // Edge history tracks the raw input even while the game is paused,
    // so a hit held across game_active rising is not counted.
    always_ff @(posedge clock) begin
        if (reset) hit_prev <= '0;
        else       hit_prev <= bus.hit;
    end

    assign rise = bus.hit & ~hit_prev;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_lane
        logic [SCORE_W:0]   inc;
        logic [SCORE_W:0]   sum;
        logic [SCORE_W-1:0] acc_q;

        always_comb begin
            inc = INC_X1;
            case (bus.powerup[2*p +: 2])
                PU_X1:     inc = INC_X1;
                PU_X2:     inc = INC_X2;
                PU_X4:     inc = INC_X4;
                PU_SNITCH: inc = INC_SN;
                default:   inc = INC_X1;
            endcase
            sum = {1'b0, acc_q} + inc;
        end

        always_ff @(posedge clock) begin
            if (reset)
                acc_q <= '0;
            else if (bus.clear)
                acc_q <= '0;
            else if (bus.game_active && rise[p])
                acc_q <= (sum > MAX_S) ? MAX_S[SCORE_W-1:0] : sum[SCORE_W-1:0];
        end

        assign acc[p] = acc_q;
    end

    always_comb begin
        cv_din = '0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            if (ptr == 3'(p)) cv_din = acc[p];
    end

    bcd_converter #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_cv (
        .clock (clock),
        .reset (reset),
        .start (1'b1),
        .din   (cv_din),
        .done  (cv_done),
        .bcd   (cv_bcd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            bank         <= '0;
            ptr          <= '0;
            bcd_valid_q  <= 1'b0;
            bcd_player_q <= '0;
        end else begin
            bcd_valid_q <= cv_done;
            if (cv_done) begin
                for (int p = 0; p < NUM_PLAYERS; p++)
                    if (ptr == 3'(p)) bank[p] <= cv_bcd;
                bcd_player_q <= ptr;
                ptr          <= (ptr == 3'(NUM_PLAYERS - 1)) ? 3'd0 : ptr + 3'd1;
            end
        end
    end

    assign bus.score      = acc;
    assign bus.bcd_digits = bank;
    assign bus.bcd_valid  = bcd_valid_q;
    assign bus.bcd_player = bcd_player_q;

`ifdef SCORE_ENGINE_LEADER_EN
    logic [2:0]         lead_idx;
    logic [SCORE_W-1:0] best;
    logic               tie;
    logic [2:0]         leader_q;
    logic               leader_tie_q;

    // Strict greater-than keeps the lowest index on equal scores.
    always_comb begin
        best     = acc[0];
        lead_idx = '0;
        for (int p = 1; p < NUM_PLAYERS; p++) begin
            if (acc[p] > best) begin
                best     = acc[p];
                lead_idx = 3'(p);
            end
        end
        tie = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++)
            if (acc[p] == best && 3'(p) != lead_idx) tie = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            leader_q     <= '0;
            leader_tie_q <= 1'b0;
        end else begin
            leader_q     <= lead_idx;
            leader_tie_q <= tie;
        end
    end

    assign bus.leader     = leader_q;
    assign bus.leader_tie = leader_tie_q;
`else
    assign bus.leader     = '0;
    assign bus.leader_tie = 1'b0;
`endif

endmodule

// File: tb/tb_score_engine.sv
// Directed bench for score_engine at default parameters; leader checks
// follow SCORE_ENGINE_LEADER_EN.
module tb_score_engine;
    import score_pkg::*;

    localparam int NP = 4;
    localparam int SW = 14;
    localparam int DG = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    score_engine_if #(.NUM_PLAYERS(NP), .SCORE_W(SW), .DIGITS(DG)) sif ();

    score_engine #(
        .NUM_PLAYERS(NP), .SCORE_W(SW), .DIGITS(DG),
        .BASE_POINTS(10), .SNITCH_BONUS(150)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (sif)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [SW-1:0] sc(input int p);
        return sif.score[p*SW +: SW];
    endfunction

    function automatic logic [4*DG-1:0] bk(input int p);
        return sif.bcd_digits[p*4*DG +: 4*DG];
    endfunction

    task automatic do_reset();
        reset           = 1'b1;
        sif.hit         = '0;
        sif.powerup     = '0;
        sif.clear       = 1'b0;
        sif.game_active = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse(input int p, input logic [1:0] code);
        sif.powerup[2*p +: 2] = code;
        sif.hit[p] = 1'b1;
        tick();
        sif.hit[p] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        sif.game_active = 1'b1;
        sif.clear       = 1'b0;
        sif.hit         = '1;
        sif.powerup     = '1;
        tick();
        tick();
        checks++; if (sif.score !== '0) begin errors++; $display("FAIL reset_score got=%h exp=0", sif.score); end
        checks++; if (sif.bcd_digits !== '0) begin errors++; $display("FAIL reset_bcd got=%h exp=0", sif.bcd_digits); end
        checks++; if (sif.bcd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", sif.bcd_valid); end
        checks++; if (sif.bcd_player !== 3'd0) begin errors++; $display("FAIL reset_player got=%0d exp=0", sif.bcd_player); end
        checks++; if (sif.leader !== 3'd0) begin errors++; $display("FAIL reset_leader got=%0d exp=0", sif.leader); end
        checks++; if (sif.leader_tie !== 1'b0) begin errors++; $display("FAIL reset_tie got=%b exp=0", sif.leader_tie); end
    endtask

    task automatic test_hit_edge();
        logic [NP*SW-1:0] exp_s;
        bit found;
        do_reset();
        sif.game_active = 1'b1;
        sif.hit[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (sc(0) !== 14'd10) begin errors++; $display("FAIL held_hit cyc=%0d got=%0d exp=10", i, sc(0)); end
        end
        sif.hit[0] = 1'b0;
        tick();
        exp_s = '0;
        exp_s[0 +: SW] = 14'd10;
        checks++; if (sif.score !== exp_s) begin errors++; $display("FAIL held_hit_all got=%h exp=%h", sif.score, exp_s); end
        found = 1'b0;
        for (int i = 0; i < 68; i++) begin
            if (bk(0) === 16'h0010) begin found = 1'b1; break; end
            tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL bank0 got=%h exp=0010", bk(0)); end
    endtask

    task automatic test_multi();
        logic [NP*SW-1:0] exp_s;
        do_reset();
        sif.game_active = 1'b1;
        sif.powerup = {PU_X1, PU_X4, PU_X2, PU_X1};
        sif.hit = 4'b0110;
        tick();
        exp_s = '0;
        exp_s[1*SW +: SW] = 14'd20;
        exp_s[2*SW +: SW] = 14'd40;
        checks++; if (sif.score !== exp_s) begin errors++; $display("FAIL multi got=%h exp=%h", sif.score, exp_s); end
        sif.hit = '0;
        tick();
        checks++; if (sif.score !== exp_s) begin errors++; $display("FAIL multi_hold got=%h exp=%h", sif.score, exp_s); end
    endtask

    task automatic test_saturate();
        int seen;
        do_reset();
        sif.game_active = 1'b1;
        for (int i = 0; i < 66; i++) pulse(3, PU_SNITCH);
        pulse(3, PU_X4);
        pulse(3, PU_X4);
        pulse(3, PU_X1);
        checks++; if (sc(3) !== 14'd9990) begin errors++; $display("FAIL sat_pre got=%0d exp=9990", sc(3)); end
        pulse(3, PU_SNITCH);
        checks++; if (sc(3) !== 14'd9999) begin errors++; $display("FAIL sat got=%0d exp=9999", sc(3)); end
        pulse(3, PU_SNITCH);
        checks++; if (sc(3) !== 14'd9999) begin errors++; $display("FAIL sat_again got=%0d exp=9999", sc(3)); end
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (sif.bcd_valid === 1'b1 && sif.bcd_player === 3'd3) seen++;
            if (seen == 2) break;
        end
        checks++;
        if (seen < 2) begin
            errors++; $display("FAIL bank3_timeout got=%0d refreshes exp=2", seen);
        end else if (bk(3) !== 16'h9999) begin
            errors++; $display("FAIL bank3 got=%h exp=9999", bk(3));
        end
        checks++; if (sif.bcd_digits[47:0] !== 48'h0) begin errors++; $display("FAIL bank_others got=%h exp=0", sif.bcd_digits[47:0]); end
    endtask

    task automatic test_clear_inactive();
        do_reset();
        sif.game_active = 1'b1;
        pulse(0, PU_X1);
        checks++; if (sc(0) !== 14'd10) begin errors++; $display("FAIL pre_clear got=%0d exp=10", sc(0)); end
        sif.hit[0] = 1'b1;
        sif.clear  = 1'b1;
        tick();
        checks++; if (sc(0) !== 14'd0) begin errors++; $display("FAIL clear_hit got=%0d exp=0", sc(0)); end
        sif.clear  = 1'b0;
        sif.hit[0] = 1'b0;
        tick();
        sif.game_active = 1'b0;
        pulse(0, PU_X4);
        checks++; if (sc(0) !== 14'd0) begin errors++; $display("FAIL inactive got=%0d exp=0", sc(0)); end
        sif.game_active = 1'b1;
        tick();
        tick();
        checks++; if (sc(0) !== 14'd0) begin errors++; $display("FAIL not_queued got=%0d exp=0", sc(0)); end
        sif.game_active = 1'b0;
        sif.hit[0] = 1'b1;
        tick();
        tick();
        sif.game_active = 1'b1;
        tick();
        tick();
        checks++; if (sc(0) !== 14'd0) begin errors++; $display("FAIL held_across_active got=%0d exp=0", sc(0)); end
        sif.hit[0] = 1'b0;
        tick();
    endtask

    task automatic test_leader();
        logic [NP*SW-1:0] exp_s;
        logic [2:0]       exp_l;
        logic             exp_t;
        do_reset();
        sif.game_active = 1'b1;
        for (int i = 0; i < 3; i++) pulse(0, PU_X1);
        pulse(1, PU_X4);
        pulse(1, PU_X1);
        pulse(2, PU_X4);
        pulse(2, PU_X1);
        tick();
        exp_s = '0;
        exp_s[0*SW +: SW] = 14'd30;
        exp_s[1*SW +: SW] = 14'd50;
        exp_s[2*SW +: SW] = 14'd50;
        checks++; if (sif.score !== exp_s) begin errors++; $display("FAIL leader_scores got=%h exp=%h", sif.score, exp_s); end
`ifdef SCORE_ENGINE_LEADER_EN
        exp_l = 3'd1; exp_t = 1'b1;
`else
        exp_l = 3'd0; exp_t = 1'b0;
`endif
        checks++; if (sif.leader !== exp_l) begin errors++; $display("FAIL leader_tie_case got=%0d exp=%0d", sif.leader, exp_l); end
        checks++; if (sif.leader_tie !== exp_t) begin errors++; $display("FAIL tie_flag got=%b exp=%b", sif.leader_tie, exp_t); end
        pulse(2, PU_X1);
        tick();
`ifdef SCORE_ENGINE_LEADER_EN
        exp_l = 3'd2; exp_t = 1'b0;
`else
        exp_l = 3'd0; exp_t = 1'b0;
`endif
        checks++; if (sif.leader !== exp_l) begin errors++; $display("FAIL leader_unique got=%0d exp=%0d", sif.leader, exp_l); end
        checks++; if (sif.leader_tie !== exp_t) begin errors++; $display("FAIL tie_unique got=%b exp=%b", sif.leader_tie, exp_t); end
    endtask

    task automatic test_reset_mid_shift();
        bit seen;
        int n;
        do_reset();
        sif.game_active = 1'b1;
        pulse(1, PU_X2);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sif.bcd_valid === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL pre_valid_timeout got=0 exp=1"); end
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        checks++; if (sif.bcd_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", sif.bcd_valid); end
        checks++; if (sif.score !== '0 || sif.bcd_digits !== '0) begin errors++; $display("FAIL rst_mid_data got=%h/%h exp=0", sif.score, sif.bcd_digits); end
        checks++; if (sif.bcd_player !== 3'd0 || sif.leader !== 3'd0 || sif.leader_tie !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ctrl got=%0d/%0d/%b exp=0", sif.bcd_player, sif.leader, sif.leader_tie);
        end
        reset = 1'b0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (sif.bcd_valid === 1'b1) begin n = i; break; end
        end
        checks++; if (n != SW + 3) begin errors++; $display("FAIL first_valid_latency got=%0d exp=%0d", n, SW + 3); end
        checks++; if (sif.bcd_player !== 3'd0) begin errors++; $display("FAIL first_valid_player got=%0d exp=0", sif.bcd_player); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_hit_edge();
        test_multi();
        test_saturate();
        test_clear_inactive();
        test_leader();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
